// File: rtl/mag_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package mag_pkg;

  // Width of one compare step.
  localparam int NIB = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Cascade state carried from the MSB nibble downwards.
  typedef enum logic [1:0] {
    EQ = 2'b00,
    GT = 2'b01,
    LT = 2'b10
  } cas_e;

  // Map a cascade state onto the {gt, eq, lt} output flags.
  function automatic logic [2:0] cas_flags(input cas_e c);
    logic [2:0] f;
    case (c)
      GT:      f = 3'b100;
      LT:      f = 3'b001;
      default: f = 3'b010;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mag_nib.sv
// Combinational 4-bit magnitude compare stage with cascade input.
// A decided cascade (GT/LT) passes through; EQ takes this nibble's verdict.
module mag_nib
  import mag_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  cas_e           cascade,
  output cas_e           result
);

  // Resolve the cascade with the local nibble compare.
  always_comb begin
    result = cascade;
    if (cascade == EQ) begin
      if (a > b) begin
        result = GT;
      end else if (a < b) begin
        result = LT;
      end
    end
  end

endmodule

// File: rtl/mag_seq.sv
// Sequential magnitude comparator: scans captured operands one nibble per
// cycle from the MSB end through a single mag_nib stage.
// Optional feature: define MAG_SIGNED_EN to add the signed_cmp port, which
// selects a two's-complement compare by flipping both operand sign bits.
module mag_seq
  import mag_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EARLY = 1
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MAG_SIGNED_EN
  input  logic             signed_cmp,
`endif
  output logic             busy,
  output logic             done,
  output logic             gto,
  output logic             eqo,
  output logic             lto
);

  localparam int NNIB = WIDTH / NIB;
  localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  cas_e             cas_q, cas_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       res_q, res_d;
  logic             cmp_signed;
  cas_e             nib_res;

`ifdef MAG_SIGNED_EN
  logic sgn_q, sgn_d;
  assign cmp_signed = sgn_q;
`else
  assign cmp_signed = 1'b0;
`endif

  // Split the captured operands into nibbles; the top nibble carries the
  // sign-bit flip that turns a signed compare into an unsigned one.
  logic [NIB-1:0] a_nib [NNIB];
  logic [NIB-1:0] b_nib [NNIB];

  genvar gi;
  generate
    for (gi = 0; gi < NNIB; gi++) begin : g_nib
      if (gi == NNIB - 1) begin : g_top
        assign a_nib[gi] = a_q[gi*NIB +: NIB] ^ {cmp_signed, {(NIB-1){1'b0}}};
        assign b_nib[gi] = b_q[gi*NIB +: NIB] ^ {cmp_signed, {(NIB-1){1'b0}}};
      end else begin : g_low
        assign a_nib[gi] = a_q[gi*NIB +: NIB];
        assign b_nib[gi] = b_q[gi*NIB +: NIB];
      end
    end
  endgenerate

  mag_nib u_nib (
    .a       (a_nib[idx_q]),
    .b       (b_nib[idx_q]),
    .cascade (cas_q),
    .result  (nib_res)
  );

  // Next-state logic: capture on start, step nibbles in RUN, pulse in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cas_d   = cas_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef MAG_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
`ifdef MAG_SIGNED_EN
          sgn_d   = signed_cmp;
`endif
          idx_d   = IW'(NNIB - 1);
          cas_d   = EQ;
          state_d = RUN;
        end
      end
      RUN: begin
        cas_d = nib_res;
        if ((idx_q == '0) || ((EARLY != 0) && (nib_res != EQ))) begin
          // Result flags load on the edge into DONE so they change together with done.
          res_d   = cas_flags(nib_res);
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cas_q   <= EQ;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= 3'b010;
`ifdef MAG_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cas_q   <= cas_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef MAG_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign {gto, eqo, lto} = res_q;

endmodule

// File: tb/tb_mag_seq.sv
// Scoreboard bench for mag_seq: one EARLY=1 and one EARLY=0 instance share
// stimulus; a behavioural model predicts result and done cycle per accept.
module tb_mag_seq;

  localparam int W  = 32;
  localparam int NN = W / 4;
`ifdef MAG_SIGNED_EN
  localparam bit SG_EN = 1'b1;
`else
  localparam bit SG_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } exp_t;

  logic         clk;
  logic         resetl;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         sg;

  logic e_busy, e_done, e_gto, e_eqo, e_lto;
  logic f_busy, f_done, f_gto, f_eqo, f_lto;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         cnt_m [2];
  logic [2:0] last_m [2];
  exp_t       sb0 [$];
  exp_t       sb1 [$];

  mag_seq #(.WIDTH(W), .EARLY(1)) u_early (
    .clk(clk), .resetl(resetl), .start(start), .a(op_a), .b(op_b),
`ifdef MAG_SIGNED_EN
    .signed_cmp(sg),
`endif
    .busy(e_busy), .done(e_done), .gto(e_gto), .eqo(e_eqo), .lto(e_lto)
  );

  mag_seq #(.WIDTH(W), .EARLY(0)) u_full (
    .clk(clk), .resetl(resetl), .start(start), .a(op_a), .b(op_b),
`ifdef MAG_SIGNED_EN
    .signed_cmp(sg),
`endif
    .busy(f_busy), .done(f_done), .gto(f_gto), .eqo(f_eqo), .lto(f_lto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y, input bit early);
    if (!early) return NN + 1;
    for (int k = 0; k < NN; k++) begin
      if (x[(W-1-4*k) -: 4] != y[(W-1-4*k) -: 4]) return k + 2;
    end
    return NN + 1;
  endfunction

  function automatic logic [2:0] exp_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return 3'b010;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt_m[i]  = 0;
      last_m[i] = 3'b010;
    end
    sb0.delete();
    sb1.delete();
  endtask

  // Model the accept/countdown of each instance at the rising edge.
  task automatic model_edge();
    exp_t e;
    int   lat;
    cyc++;
    if (!resetl) return;
    for (int i = 0; i < 2; i++) begin
      if (cnt_m[i] != 0) begin
        cnt_m[i]--;
      end else if (start) begin
        lat   = exp_lat(op_a, op_b, (i == 0));
        e.res = exp_res(op_a, op_b, sg & SG_EN);
        e.cyc = cyc + lat - 1;
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        cnt_m[i] = lat;
      end
    end
  endtask

  task automatic mon(input int i, input logic dn, input logic bz, input logic [2:0] res);
    exp_t e;
    logic exp_dn;
    exp_dn = 1'b0;
    if (i == 0) begin
      if (sb0.size() > 0 && sb0[0].cyc == cyc) begin exp_dn = 1'b1; e = sb0.pop_front(); end
    end else begin
      if (sb1.size() > 0 && sb1[0].cyc == cyc) begin exp_dn = 1'b1; e = sb1.pop_front(); end
    end
    check_eq($sformatf("busy%0d", i), bz, (cnt_m[i] != 0));
    check_eq($sformatf("done%0d", i), dn, exp_dn);
    if (exp_dn) begin
      check_eq($sformatf("result%0d", i), res, e.res);
      last_m[i] = e.res;
      $display("cmp inst=%0d cyc=%0d flags(gt,eq,lt)=%b expected=%b", i, cyc, res, e.res);
    end else begin
      check_eq($sformatf("hold%0d", i), res, last_m[i]);
    end
  endtask

  // One clock: model at the rising edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    mon(0, e_done, e_busy, {e_gto, e_eqo, e_lto});
    mon(1, f_done, f_busy, {f_gto, f_eqo, f_lto});
  endtask

  task automatic wait_idle(input bit toggle);
    for (int k = 0; k < 40 && (cnt_m[0] != 0 || cnt_m[1] != 0); k++) begin
      if (toggle) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      step();
    end
    check_eq("idle", {e_busy, f_busy}, 2'b00);
  endtask

  task automatic do_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input bit toggle);
    start = 1'b1;
    op_a  = x;
    op_b  = y;
    sg    = s;
    step();
    start = 1'b0;
    wait_idle(toggle);
    step();
  endtask

  initial begin
    logic [W-1:0] x, y, m;
    resetl = 1'b0;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    sg     = 1'b0;
    model_reset();
    repeat (3) step();
    resetl = 1'b1;
    step();

    // Directed cases: equal, MSB differs (unsigned/signed), LSB-only, extremes.
    do_cmp(32'h12345678, 32'h12345678, 1'b0, 1'b0);
    do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
    do_cmp(32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0);
    do_cmp(32'h00000001, 32'h00000002, 1'b0, 1'b1);
    do_cmp(32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_cmp(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_cmp(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
    do_cmp(32'h00000000, 32'h00000000, 1'b0, 1'b0);
    do_cmp(32'h00000000, 32'h00000000, 1'b0, 1'b0);

    // Random compares with shared nibbles so the early exit lands anywhere.
    for (int n = 0; n < 30; n++) begin
      x = $urandom;
      m = '0;
      for (int k = 0; k < NN; k++) if ($urandom_range(0, 1) == 1) m[k*4 +: 4] = 4'hF;
      y = (x & ~m) | (32'($urandom) & m);
      do_cmp(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // start held high: equal operands, then fresh operands every cycle.
    start = 1'b1;
    op_a  = 32'hCAFE0123;
    op_b  = 32'hCAFE0123;
    sg    = 1'b0;
    repeat (40) step();
    for (int n = 0; n < 30; n++) begin
      op_a = $urandom;
      op_b = (n % 2 == 0) ? op_a ^ (32'h1 << $urandom_range(0, W - 1)) : 32'($urandom);
      step();
    end
    start = 1'b0;
    wait_idle(1'b0);
    step();

    // Reset pulse in the fourth cycle of a compare aborts it silently.
    start = 1'b1;
    op_a  = 32'h00000005;
    op_b  = 32'h00000003;
    step();
    start = 1'b0;
    repeat (3) step();
    resetl = 1'b0;
    model_reset();
    repeat (2) step();
    resetl = 1'b1;
    repeat (12) step();
    do_cmp(32'h00000005, 32'h00000003, 1'b0, 1'b0);

    check_eq("sb0_drained", sb0.size(), 0);
    check_eq("sb1_drained", sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
